// File: rtl/button_debouncer_pkg.sv
// rtl/button_debouncer_pkg.sv - FSM state encodings and default timing constants for the button debouncer
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // 10 ms and 1 s at a 100 MHz system clock
    localparam int DEFAULT_STABLE_CYCLES = 1_000_000;
    localparam int DEFAULT_LONG_CYCLES   = 100_000_000;

    // HELD and RELEASE_WAIT both report the button as pressed
    function automatic logic is_pressed_state(input state_t s);
        return (s == HELD) || (s == RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// rtl/button_debouncer_if.sv - raw button input and debounced outputs grouped as one bundle
interface button_debouncer_if;

    logic       button;
    logic       level;
    logic       press;
    logic       release_strobe;
    logic [7:0] press_count;
    logic       long_press;

    modport master (
        input  button,
        output level,
        output press,
        output release_strobe,
        output press_count,
        output long_press
    );

    modport slave (
        output button,
        input  level,
        input  press,
        input  release_strobe,
        input  press_count,
        input  long_press
    );

endinterface

// File: rtl/button_debouncer_sync.sv
// rtl/button_debouncer_sync.sv - reusable two-flop synchroniser resetting to 0
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - button debouncer top; BUTTON_DEBOUNCER_LONG_PRESS_EN enables the long-press strobe
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int LONG_CYCLES   = DEFAULT_LONG_CYCLES,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    button_debouncer_if.master  bus
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    if (STABLE_CYCLES < 2) begin : g_bad_stable_cycles
        $error("STABLE_CYCLES must be at least 2");
    end
    if (LONG_CYCLES <= STABLE_CYCLES) begin : g_bad_long_cycles
        $error("LONG_CYCLES must exceed STABLE_CYCLES");
    end

    logic          pressed_raw;
    logic          s;
    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          press_next, release_next;
    logic          press_q, release_q;
    logic [7:0]    count;

    assign pressed_raw = ACTIVE_LOW ? ~bus.button : bus.button;

    sync_2ff u_sync (
        .clock (clock),
        .reset (reset),
        .d     (pressed_raw),
        .q     (s)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            count     <= 8'd0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            press_q   <= press_next;
            release_q <= release_next;
            if (press_next) begin
                count <= count + 8'd1;
            end
        end
    end

    // cnt holds the number of consecutive samples that already agree with the pending change
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        press_next   = 1'b0;
        release_next = 1'b0;
        case (state)
            IDLE: begin
                if (s) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                    state_next = HELD;
                    cnt_next   = '0;
                    press_next = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            HELD: begin
                if (!s) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = CW'(1);
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                    state_next   = IDLE;
                    cnt_next     = '0;
                    release_next = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign bus.level          = is_pressed_state(state);
    assign bus.press          = press_q;
    assign bus.release_strobe = release_q;
    assign bus.press_count    = count;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_CYCLES + 1);

    logic [HW-1:0] hold;
    logic          long_q;

    // hold saturates at LONG_CYCLES so the strobe cannot repeat within one hold
    always_ff @(posedge clock) begin
        if (reset) begin
            hold   <= '0;
            long_q <= 1'b0;
        end else begin
            long_q <= is_pressed_state(state) && (hold == HW'(LONG_CYCLES - 1));
            if (press_next || (state_next == IDLE)) begin
                hold <= '0;
            end else if (is_pressed_state(state) && (hold != HW'(LONG_CYCLES))) begin
                hold <= hold + HW'(1);
            end
        end
    end

    assign bus.long_press = long_q;
`else
    assign bus.long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - self-checking bench: run-length reference model, scoreboard and segment tables
module tb_button_debouncer;

    localparam int STABLE = 4;
    localparam int LONG   = 16;
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    button_debouncer_if bif ();

    button_debouncer #(
        .STABLE_CYCLES (STABLE),
        .LONG_CYCLES   (LONG),
        .ACTIVE_LOW    (1'b0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif)
    );

    typedef struct {
        logic       level;
        logic       press;
        logic       rel;
        logic       long_p;
        logic [7:0] count;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       btn;
        int         len;
        logic       exp_level;
        logic [7:0] exp_count;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   press_seen = 0, release_seen = 0, long_seen = 0;
    int   last_press = -1, last_release = -1, last_long = -1;

    // Reference: a change is accepted once STABLE consecutive synchronised samples disagree with level
    logic       h1 = 1'b0, h2 = 1'b0, lvl_m = 1'b0;
    int         run_m = 0, hold_m = 0;
    logic [7:0] cnt_m = 8'd0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic model_edge(input logic r, input logic b);
        logic samp, pre, pe, re, le;
        pe = 1'b0; re = 1'b0; le = 1'b0;
        if (r) begin
            h1 = 1'b0; h2 = 1'b0; lvl_m = 1'b0;
            run_m = 0; hold_m = 0; cnt_m = 8'd0;
        end else begin
            samp = h2; h2 = h1; h1 = b;
            pre  = lvl_m;
            le   = LONG_EN && pre && (hold_m == LONG - 1);
            if (pre && hold_m < LONG) hold_m++;
            if (samp !== lvl_m) run_m++; else run_m = 0;
            if (run_m == STABLE) begin
                lvl_m  = ~lvl_m;
                run_m  = 0;
                hold_m = 0;
                if (lvl_m) begin pe = 1'b1; cnt_m = cnt_m + 8'd1; end
                else re = 1'b1;
            end
        end
        sb.push_back('{lvl_m, pe, re, le, cnt_m});
    endtask

    task automatic step(input logic r, input logic b);
        exp_t e;
        reset      = r;
        bif.button = b;
        model_edge(r, b);
        @(posedge clock);
        #1;
        cyc++;
        if (sb.size() == 0) begin
            check("scoreboard_underrun", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("level",       {31'd0, bif.level},          {31'd0, e.level});
            check("press",       {31'd0, bif.press},          {31'd0, e.press});
            check("release",     {31'd0, bif.release_strobe}, {31'd0, e.rel});
            check("long_press",  {31'd0, bif.long_press},     {31'd0, e.long_p});
            check("press_count", {24'd0, bif.press_count},    {24'd0, e.count});
        end
        if (bif.press === 1'b1)          begin press_seen++;   last_press   = cyc; end
        if (bif.release_strobe === 1'b1) begin release_seen++; last_release = cyc; end
        if (bif.long_press === 1'b1)     begin long_seen++;    last_long    = cyc; end
    endtask

    task automatic run(input logic r, input logic b, input int n);
        for (int i = 0; i < n; i++) step(r, b);
    endtask

    task automatic clear_seen();
        press_seen = 0; release_seen = 0; long_seen = 0;
        last_press = -1; last_release = -1; last_long = -1;
    endtask

    vec_t vt[11];
    int   t0;

    initial begin
        bif.button = 1'b0;
        vt[0]  = '{1'b1, 1'b1,  3, 1'b0, 8'd0};
        vt[1]  = '{1'b0, 1'b1, 20, 1'b1, 8'd1};
        vt[2]  = '{1'b0, 1'b0,  8, 1'b0, 8'd1};
        vt[3]  = '{1'b0, 1'b1,  2, 1'b0, 8'd1};
        vt[4]  = '{1'b0, 1'b0,  2, 1'b0, 8'd1};
        vt[5]  = '{1'b0, 1'b1,  2, 1'b0, 8'd1};
        vt[6]  = '{1'b0, 1'b0,  2, 1'b0, 8'd1};
        vt[7]  = '{1'b0, 1'b1, 10, 1'b1, 8'd2};
        vt[8]  = '{1'b0, 1'b0, 10, 1'b0, 8'd2};
        vt[9]  = '{1'b0, 1'b1,  3, 1'b0, 8'd2};
        vt[10] = '{1'b0, 1'b0,  8, 1'b0, 8'd2};

        for (int i = 0; i < 11; i++) begin
            run(vt[i].rst, vt[i].btn, vt[i].len);
            check($sformatf("vec%0d_level", i), {31'd0, bif.level},       {31'd0, vt[i].exp_level});
            check($sformatf("vec%0d_count", i), {24'd0, bif.press_count}, {24'd0, vt[i].exp_count});
        end

        // Clean press with exact latency, then release with mirrored latency
        run(1'b1, 1'b1, 3);
        clear_seen();
        t0 = cyc + 1;
        run(1'b0, 1'b1, 20);
        check("clean_press_count", press_seen, 1);
        check("clean_press_time", last_press, t0 + STABLE + 1);
        t0 = cyc + 1;
        run(1'b0, 1'b0, 10);
        check("clean_release_count", release_seen, 1);
        check("clean_release_time", last_release, t0 + STABLE + 1);

        // Bounce 1,0,1,0 then settle high
        clear_seen();
        run(1'b0, 1'b1, 2); run(1'b0, 1'b0, 2); run(1'b0, 1'b1, 2); run(1'b0, 1'b0, 2);
        t0 = cyc + 1;
        run(1'b0, 1'b1, 12);
        check("bounce_press_count", press_seen, 1);
        check("bounce_press_time", last_press, t0 + STABLE + 1);

        // Release from HELD
        t0 = cyc + 1;
        run(1'b0, 1'b0, 10);
        check("held_release_time", last_release, t0 + STABLE + 1);

        // Three-sample glitch must be ignored
        clear_seen();
        run(1'b0, 1'b1, 3);
        run(1'b0, 1'b0, 10);
        check("glitch_press_count", press_seen, 0);
        check("glitch_level", {31'd0, bif.level}, 32'd0);

        // 256 presses wrap the tally
        run(1'b1, 1'b0, 2);
        clear_seen();
        for (int p = 0; p < 256; p++) begin
            run(1'b0, 1'b1, 7);
            run(1'b0, 1'b0, 7);
        end
        check("wrap_presses", press_seen, 256);
        check("wrap_count", {24'd0, bif.press_count}, 32'd0);

        // Reset while held, then re-debounce the still-held button
        run(1'b0, 1'b1, 8);
        check("pre_reset_level", {31'd0, bif.level}, 32'd1);
        run(1'b1, 1'b1, 1);
        check("reset_level", {31'd0, bif.level}, 32'd0);
        check("reset_count", {24'd0, bif.press_count}, 32'd0);
        clear_seen();
        t0 = cyc + 1;
        run(1'b0, 1'b1, 10);
        check("reheld_press_time", last_press, t0 + STABLE + 1);

        // Long hold
        run(1'b1, 1'b0, 2);
        clear_seen();
        run(1'b0, 1'b1, 40);
        check("long_press_count", long_seen, LONG_EN ? 1 : 0);
        check("long_press_delay", (long_seen == 1) ? (last_long - last_press) : -1, LONG_EN ? LONG : -1);
        run(1'b0, 1'b0, 10);

        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
